// File: rtl/gauss_pkg.sv
// gauss_pkg: shared state type, pixel flags and default frame geometry
// for the Gaussian-stage upsample reader.
package gauss_pkg;

    localparam int DEF_ROW_PIXELS = 400;
    localparam int DEF_PAD_WORDS  = 2;
    localparam int DEF_ROWS       = 300;

    localparam int ROW_WORDS   = DEF_ROW_PIXELS + DEF_PAD_WORDS;
    localparam int OUT_W       = DEF_ROW_PIXELS * 2;
    localparam int OUT_H       = DEF_ROWS * 2;
    localparam int FRAME_WORDS = ROW_WORDS * DEF_ROWS;

    localparam int PIX_W = 8;
    localparam int CNT_W = $clog2(ROW_WORDS + 1);
    localparam int X_W   = $clog2(OUT_W);
    localparam int ROW_W = $clog2(DEF_ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EMIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic sol;
    } flags_t;

endpackage

// File: rtl/gauss_upsample_reader_if.sv
// gauss_upsample_reader_if: FIFO drain port plus the upsampled pixel
// stream; master is the reader, slave is the FIFO/downstream side.
interface gauss_upsample_reader_if;
    import gauss_pkg::*;

    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             fifo_valid;
    logic [PIX_W-1:0] fifo_dout;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_sol;
    logic             out_eol;
    logic             out_sof;

    modport master (
        input  fifo_empty, fifo_valid, fifo_dout, out_ready,
        output fifo_rd_en, out_valid, out_data, out_sol, out_eol, out_sof
    );

    modport slave (
        output fifo_empty, fifo_valid, fifo_dout, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_sol, out_eol, out_sof
    );

endinterface

// File: rtl/gauss_line_buf.sv
// gauss_line_buf: one-row simple dual-port RAM, synchronous write and
// registered read.
module gauss_line_buf
    import gauss_pkg::*;
#(
    parameter int DEPTH = DEF_ROW_PIXELS,
    parameter int AW    = $clog2(DEF_ROW_PIXELS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/gauss_upsample_reader.sv
// gauss_upsample_reader: drains padded Gaussian rows from the FIFO and
// emits each row doubled in width, twice, as a valid/ready pixel stream.
module gauss_upsample_reader
    import gauss_pkg::*;
#(
    parameter int ROW_PIXELS = DEF_ROW_PIXELS,
    parameter int PAD_WORDS  = DEF_PAD_WORDS,
    parameter int ROWS       = DEF_ROWS,
    parameter int H_SCALE    = 2,
    parameter int V_SCALE    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    gauss_upsample_reader_if.master bus,
    output logic                    frame_done,
    output logic                    proto_err
);

    localparam int N_WORDS = ROW_PIXELS + PAD_WORDS;
    localparam int N_OUT   = ROW_PIXELS * H_SCALE;
    localparam int CW      = $clog2(N_WORDS + 1);
    localparam int XW      = $clog2(N_OUT);
    localparam int AW      = XW - 1;
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] WORDS_C  = CW'(N_WORDS);
    localparam logic [CW-1:0] PIX_C    = CW'(ROW_PIXELS);
    localparam logic [XW-1:0] X_LAST   = XW'(N_OUT - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic          REP_LAST = 1'(V_SCALE - 1);

    state_t state, state_nx;

    logic [CW-1:0] req_cnt, wcnt;
    logic [XW-1:0] x;
    logic          rep;
    logic [RW-1:0] row_cnt;

    logic rd_en, wr_ok, wr_last;
    logic issue, issue_last, drained, pop;
    logic [1:0] occ;
    flags_t issue_flags;

    logic             v_b;
    flags_t           meta_b;
    logic [PIX_W-1:0] rd_data;

    logic             head_v, skid_v;
    logic [PIX_W-1:0] head_d, skid_d;
    flags_t           head_m, skid_m;

    gauss_line_buf #(
        .DEPTH(ROW_PIXELS),
        .AW   (AW)
    ) u_lb (
        .clk  (clk),
        .we   (wr_ok && (wcnt < PIX_C)),
        .waddr(wcnt[AW-1:0]),
        .wdata(bus.fifo_dout),
        .re   (issue),
        .raddr(x[XW-1:1]),
        .rdata(rd_data)
    );

    // occ counts the in-flight read plus both buffer slots; issuing only
    // when a slot is guaranteed keeps the skid from ever overflowing.
    always_comb begin
        pop         = head_v && bus.out_ready;
        occ         = {1'b0, v_b} + {1'b0, head_v} + {1'b0, skid_v};
        rd_en       = (state == S_READ) && !bus.fifo_empty
                      && (req_cnt < WORDS_C);
        wr_ok       = bus.fifo_valid && (state == S_READ)
                      && (req_cnt != wcnt);
        wr_last     = wr_ok && (wcnt == WORDS_C - 1'b1);
        issue       = (state == S_EMIT)
                      && ((occ < 2'd2) || ((occ == 2'd2) && pop));
        issue_last  = issue && (x == X_LAST);
        drained     = !v_b && !head_v && !skid_v;
        issue_flags.sol = (x == '0);
        issue_flags.eol = (x == X_LAST);
        issue_flags.sof = (x == '0) && !rep && (row_cnt == '0);
        frame_done  = (state == S_DONE) && drained;

        state_nx = state;
        unique case (state)
            S_IDLE: if (!bus.fifo_empty) state_nx = S_READ;
            S_READ: if (wr_last) state_nx = S_EMIT;
            S_EMIT: begin
                if (issue_last && (rep == REP_LAST)) begin
                    state_nx = (row_cnt == ROW_LAST) ? S_DONE : S_READ;
                end
            end
            S_DONE: if (drained) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = head_v;
    assign bus.out_data   = head_d;
    assign bus.out_sol    = head_m.sol;
    assign bus.out_eol    = head_m.eol;
    assign bus.out_sof    = head_m.sof;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_cnt   <= '0;
            wcnt      <= '0;
            x         <= '0;
            rep       <= 1'b0;
            row_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus.fifo_valid && !wr_ok) begin
                proto_err <= 1'b1;
            end
            if (wr_last) begin
                req_cnt <= '0;
                wcnt    <= '0;
                rep     <= 1'b0;
                x       <= '0;
            end else begin
                if (rd_en) req_cnt <= req_cnt + 1'b1;
                if (wr_ok) wcnt <= wcnt + 1'b1;
            end
            if (issue) begin
                if (issue_last) begin
                    x <= '0;
                    if (rep == REP_LAST) begin
                        rep <= 1'b0;
                        if (row_cnt != ROW_LAST) row_cnt <= row_cnt + 1'b1;
                    end else begin
                        rep <= 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (frame_done) begin
                row_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_b    <= 1'b0;
            meta_b <= '0;
        end else begin
            v_b <= issue;
            if (issue) meta_b <= issue_flags;
        end
    end

    // Head is the visible output register; skid catches the read that
    // was already in flight when downstream stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_v <= 1'b0;
            head_d <= '0;
            head_m <= '0;
            skid_v <= 1'b0;
            skid_d <= '0;
            skid_m <= '0;
        end else if (pop && skid_v) begin
            head_d <= skid_d;
            head_m <= skid_m;
            skid_v <= v_b;
            if (v_b) begin
                skid_d <= rd_data;
                skid_m <= meta_b;
            end
        end else if (pop || !head_v) begin
            head_v <= v_b;
            if (v_b) begin
                head_d <= rd_data;
                head_m <= meta_b;
            end
        end else if (v_b) begin
            skid_v <= 1'b1;
            skid_d <= rd_data;
            skid_m <= meta_b;
        end
    end

endmodule
